pcie_msg_transmitter: RTL

Transmit-side counterpart of the PCIe message receiver. It reads a message of N 256-bit beats from local SRAM, splits it into fragments of at most MAX_FRAG_BEATS payload beats, and issues each fragment as one AXI4 INCR write burst. Each burst starts with a 128-bit fragment header beat. The block sits between the SRAM read port and the AXI write master port that feeds the receiver.

---
 rtl/pcie_msg_pkg.sv | 52 +++++
 rtl/pcie_tx_beat_fifo.sv | 47 ++++
 rtl/pcie_msg_transmitter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/pcie_msg_pkg.sv
// Shared types and constants for the PCIe message transmitter: FSM states,
// fragment header layout and the AXI encodings it drives.
package pcie_msg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_HDR,
        ST_DATA,
        ST_RESP,
        ST_DONE
    } tx_state_e;

    localparam int HDR_VER_LSB    = 0;
    localparam int HDR_VER_W      = 4;
    localparam int HDR_TAG_LSB    = 4;
    localparam int HDR_TAG_W      = 4;
    localparam int HDR_SOM_BIT    = 8;
    localparam int HDR_EOM_BIT    = 9;
    localparam int HDR_SEQ_LSB    = 10;
    localparam int HDR_SEQ_W      = 6;
    localparam int HDR_NBEATS_LSB = 16;
    localparam int HDR_NBEATS_W   = 12;
    localparam int HDR_TOTLEN_LSB = 28;
    localparam int HDR_TOTLEN_W   = 12;

    localparam logic [2:0] AXI_SIZE_32B   = 3'b101;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    function automatic logic [127:0] build_hdr(
        input logic [HDR_VER_W-1:0]    ver,
        input logic [HDR_TAG_W-1:0]    tag,
        input logic                    som,
        input logic                    eom,
        input logic [HDR_SEQ_W-1:0]    seq,
        input logic [HDR_NBEATS_W-1:0] nbeats,
        input logic [HDR_TOTLEN_W-1:0] totlen
    );
        logic [127:0] h;
        h = '0;
        h[HDR_VER_LSB    +: HDR_VER_W]    = ver;
        h[HDR_TAG_LSB    +: HDR_TAG_W]    = tag;
        h[HDR_SOM_BIT]                    = som;
        h[HDR_EOM_BIT]                    = eom;
        h[HDR_SEQ_LSB    +: HDR_SEQ_W]    = seq;
        h[HDR_NBEATS_LSB +: HDR_NBEATS_W] = nbeats;
        h[HDR_TOTLEN_LSB +: HDR_TOTLEN_W] = totlen;
        return h;
    endfunction

endpackage

// File: rtl/pcie_tx_beat_fifo.sv
// Two-entry beat FIFO between the SRAM read port and the AXI W channel.
module pcie_tx_beat_fifo #(
    parameter int W = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    logic [1:0][W-1:0] mem_q;
    logic              wptr_q, rptr_q;
    logic [1:0]        cnt_q;
    logic              do_push, do_pop;

    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '0;
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= ~wptr_q;
            end
            if (do_pop)
                rptr_q <= ~rptr_q;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/pcie_msg_transmitter.sv
// Reads a message from SRAM, splits it into fragments and sends each one as
// an AXI INCR burst led by a 128-bit header beat; one burst outstanding.
module pcie_msg_transmitter
    import pcie_msg_pkg::*;
#(
    parameter logic [3:0] HDR_VERSION    = 4'h1,
    parameter int         MAX_FRAG_BEATS = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_tx_start,
    input  logic [9:0]   i_tx_saddr,
    input  logic [11:0]  i_tx_len,
    input  logic [3:0]   i_tx_tag,
    input  logic [63:0]  i_tx_dest,
    output logic         o_tx_busy,
    output logic         o_tx_done,
    output logic         o_tx_err,
    output logic         o_sram_ren,
    output logic [9:0]   o_sram_raddr,
    input  logic [255:0] i_sram_rdata,
    output logic [63:0]  O_AWADDR,
    output logic [7:0]   O_AWLEN,
    output logic [2:0]   O_AWSIZE,
    output logic [1:0]   O_AWBURST,
    output logic [6:0]   O_AWID,
    output logic [63:0]  O_AWUSER,
    output logic         O_AWVALID,
    input  logic         I_AWREADY,
    output logic [255:0] O_WDATA,
    output logic [31:0]  O_WSTRB,
    output logic         O_WLAST,
    output logic         O_WVALID,
    input  logic         I_WREADY,
    input  logic [1:0]   I_BRESP,
    input  logic         I_BVALID,
    output logic         O_BREADY
);

    function automatic logic [7:0] frag_of(input logic [11:0] rem);
        return (rem > 12'(MAX_FRAG_BEATS)) ? 8'(MAX_FRAG_BEATS) : rem[7:0];
    endfunction

    tx_state_e    state_q, state_d;
    logic [9:0]   raddr_q, raddr_d;
    logic [11:0]  rem_q, rem_d;       // payload beats left after the current fragment
    logic [7:0]   fragn_q, fragn_d;
    logic [11:0]  fragk_q, fragk_d;
    logic [7:0]   rdleft_q, rdleft_d;
    logic [7:0]   wbeat_q, wbeat_d;
    logic         err_q, err_d;
    logic         rvld_q;
    logic [11:0]  len_q;
    logic [3:0]   tag_q;
    logic [63:0]  dest_q;
    logic         accept;

    logic         fifo_full, fifo_empty, fifo_pop, rd_en, last_beat;
    logic [255:0] fifo_rdata;
    logic [1:0]   occ;
    logic [127:0] hdr;

    pcie_tx_beat_fifo #(.W(256)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rvld_q),
        .wdata_i (i_sram_rdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Reads in flight count against FIFO space so a returning beat always fits.
    assign occ   = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
    assign rd_en = (state_q == ST_HDR || state_q == ST_DATA) && (rdleft_q != 8'd0) &&
                   (({1'b0, occ} + {2'b0, rvld_q}) < 3'd2);

    assign fifo_pop  = (state_q == ST_DATA) && !fifo_empty && I_WREADY;
    assign last_beat = (wbeat_q == fragn_q - 8'd1);
    assign hdr = build_hdr(HDR_VERSION, tag_q, fragk_q == 12'd0, rem_q == 12'd0,
                           fragk_q[5:0], {4'b0, fragn_q}, len_q);

    assign O_AWADDR     = dest_q;
    assign O_AWLEN      = fragn_q;
    assign O_AWSIZE     = AXI_SIZE_32B;
    assign O_AWBURST    = AXI_BURST_INCR;
    assign O_AWID       = '0;
    assign O_AWUSER     = '0;
    assign O_WSTRB      = O_WVALID ? '1 : '0;
    assign o_sram_ren   = rd_en;
    assign o_sram_raddr = raddr_q;
    assign o_tx_busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign o_tx_done    = (state_q == ST_DONE);
    assign o_tx_err     = (state_q == ST_DONE) && err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            raddr_q  <= '0;
            rem_q    <= '0;
            fragn_q  <= '0;
            fragk_q  <= '0;
            rdleft_q <= '0;
            wbeat_q  <= '0;
            err_q    <= 1'b0;
            rvld_q   <= 1'b0;
            len_q    <= '0;
            tag_q    <= '0;
            dest_q   <= '0;
        end else begin
            state_q  <= state_d;
            raddr_q  <= raddr_d;
            rem_q    <= rem_d;
            fragn_q  <= fragn_d;
            fragk_q  <= fragk_d;
            rdleft_q <= rdleft_d;
            wbeat_q  <= wbeat_d;
            err_q    <= err_d;
            rvld_q   <= rd_en;
            if (accept) begin
                len_q  <= i_tx_len;
                tag_q  <= i_tx_tag;
                dest_q <= i_tx_dest;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        raddr_d   = raddr_q;
        rem_d     = rem_q;
        fragn_d   = fragn_q;
        fragk_d   = fragk_q;
        rdleft_d  = rdleft_q;
        wbeat_d   = wbeat_q;
        err_d     = err_q;
        accept    = 1'b0;
        O_AWVALID = 1'b0;
        O_WVALID  = 1'b0;
        O_WDATA   = '0;
        O_WLAST   = 1'b0;
        O_BREADY  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_tx_start) begin
                    if (i_tx_len == 12'd0) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_d = ST_AW;
                        raddr_d = i_tx_saddr;
                        fragn_d = frag_of(i_tx_len);
                        rem_d   = i_tx_len - {4'b0, frag_of(i_tx_len)};
                        fragk_d = '0;
                        err_d   = 1'b0;
                    end
                end
            end
            ST_AW: begin
                O_AWVALID = 1'b1;
                if (I_AWREADY) begin
                    state_d  = ST_HDR;
                    rdleft_d = fragn_q;
                    wbeat_d  = '0;
                end
            end
            ST_HDR: begin
                O_WVALID = 1'b1;
                O_WDATA  = {128'b0, hdr};
                if (I_WREADY)
                    state_d = ST_DATA;
            end
            ST_DATA: begin
                O_WVALID = !fifo_empty;
                O_WDATA  = fifo_empty ? '0 : fifo_rdata;
                O_WLAST  = !fifo_empty && last_beat;
                if (fifo_pop) begin
                    wbeat_d = wbeat_q + 8'd1;
                    if (last_beat)
                        state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                O_BREADY = 1'b1;
                if (I_BVALID) begin
                    if (I_BRESP != AXI_RESP_OKAY)
                        err_d = 1'b1;
                    if (rem_q != 12'd0) begin
                        state_d = ST_AW;
                        fragn_d = frag_of(rem_q);
                        rem_d   = rem_q - {4'b0, frag_of(rem_q)};
                        fragk_d = fragk_q + 12'd1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase

        if (rd_en) begin
            raddr_d  = raddr_q + 10'd1;
            rdleft_d = rdleft_q - 8'd1;
        end
    end

endmodule
